cmn_seq_multiplier: RTL and testbench

//   Iterative unsigned shift-add multiplier controller and datapath built from the cmn arithmetic primitives
//   (adder, left/right logical shifters, zero comparator, incrementer).

---
 rtl/cmn_seq_multiplier.sv | 212 +++++++++++++++++++++
 tb/tb_cmn_seq_multiplier.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmn_seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one add/shift step per cycle,
// operands in and product out over val/rdy handshakes.

// Two-operand adder, carry-out discarded.
module cmn_seq_mult_adder #(
    parameter int unsigned p_nbits = 64
) (
    input  logic [p_nbits-1:0] in0_i,
    input  logic [p_nbits-1:0] in1_i,
    output logic [p_nbits-1:0] sum_c_o
);
    // Modular sum; the caller guarantees no overflow
    assign sum_c_o = in0_i + in1_i;
endmodule

// Logical left shifter.
module cmn_seq_mult_lshifter #(
    parameter int unsigned p_nbits       = 64,
    parameter int unsigned p_shamt_nbits = 6
) (
    input  logic [p_nbits-1:0]       in_i,
    input  logic [p_shamt_nbits-1:0] shamt_i,
    output logic [p_nbits-1:0]       shl_c_o
);
    // Zero-fill from the right
    assign shl_c_o = in_i << shamt_i;
endmodule

// Logical right shifter.
module cmn_seq_mult_rshifter #(
    parameter int unsigned p_nbits       = 32,
    parameter int unsigned p_shamt_nbits = 5
) (
    input  logic [p_nbits-1:0]       in_i,
    input  logic [p_shamt_nbits-1:0] shamt_i,
    output logic [p_nbits-1:0]       shr_c_o
);
    // Zero-fill from the left
    assign shr_c_o = in_i >> shamt_i;
endmodule

// Equal-to-zero comparator.
module cmn_seq_mult_zero_cmp #(
    parameter int unsigned p_nbits = 32
) (
    input  logic [p_nbits-1:0] in_i,
    output logic               zero_c_o
);
    // High when every bit is clear
    assign zero_c_o = (in_i == '0);
endmodule

// Incrementer.
module cmn_seq_mult_incr #(
    parameter int unsigned p_nbits = 6
) (
    input  logic [p_nbits-1:0] in_i,
    output logic [p_nbits-1:0] inc_c_o
);
    localparam logic [p_nbits-1:0] ONE = {{(p_nbits-1){1'b0}}, 1'b1};

    // Add one, wrapping
    assign inc_c_o = in_i + ONE;
endmodule

// Top-level controller and datapath.
module cmn_seq_multiplier #(
    parameter int unsigned p_nbits      = 32,
    parameter int unsigned p_early_exit = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [p_nbits-1:0]   recv_msg_a,
    input  logic [p_nbits-1:0]   recv_msg_b,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [2*p_nbits-1:0] send_msg
);
    localparam int unsigned NB    = p_nbits;
    localparam int unsigned DW    = 2 * p_nbits;
    localparam int unsigned CW    = $clog2(p_nbits) + 1;
    localparam int unsigned ASHW  = $clog2(DW);
    localparam int unsigned BSHW  = $clog2(NB);
    localparam bit          EARLY = (p_early_exit != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [NB-1:0]   b_q, b_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            recv_rdy_q, recv_rdy_d;
    logic            send_val_q, send_val_d;

    logic [DW-1:0]   addend;
    logic [DW-1:0]   acc_sum;
    logic [DW-1:0]   a_shl;
    logic [NB-1:0]   b_shr;
    logic            b_rest_zero;
    logic [CW-1:0]   cnt_inc;
    logic            last_step;

    // Partial product selected by the current multiplier LSB
    assign addend = b_q[0] ? a_q : '0;

    cmn_seq_mult_adder #(.p_nbits(DW)) u_adder (
        .in0_i   (acc_q),
        .in1_i   (addend),
        .sum_c_o (acc_sum)
    );

    cmn_seq_mult_lshifter #(.p_nbits(DW), .p_shamt_nbits(ASHW)) u_lshift (
        .in_i    (a_q),
        .shamt_i (ASHW'(1)),
        .shl_c_o (a_shl)
    );

    cmn_seq_mult_rshifter #(.p_nbits(NB), .p_shamt_nbits(BSHW)) u_rshift (
        .in_i    (b_q),
        .shamt_i (BSHW'(1)),
        .shr_c_o (b_shr)
    );

    cmn_seq_mult_zero_cmp #(.p_nbits(NB)) u_zero (
        .in_i     (b_shr),
        .zero_c_o (b_rest_zero)
    );

    cmn_seq_mult_incr #(.p_nbits(CW)) u_incr (
        .in_i    (cnt_q),
        .inc_c_o (cnt_inc)
    );

    // Final step: full count reached, or no multiplier bits left when exiting early
    assign last_step = (cnt_q == CW'(NB - 1)) || (EARLY && b_rest_zero);

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (recv_val && recv_rdy_q) begin
                    a_d     = DW'(recv_msg_a);
                    b_d     = recv_msg_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_sum;
                a_d   = a_shl;
                b_d   = b_shr;
                cnt_d = cnt_inc;
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (send_val_q && send_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags follow the state being entered so they are registered
        recv_rdy_d = (state_d == ST_IDLE);
        send_val_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            recv_rdy_q <= 1'b0;
            send_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            recv_rdy_q <= recv_rdy_d;
            send_val_q <= send_val_d;
        end
    end

    assign recv_rdy = recv_rdy_q;
    assign send_val = send_val_q;
    // Accumulator is frozen in DONE, so the product holds under backpressure
    assign send_msg = acc_q;

endmodule

// File: tb/tb_cmn_seq_multiplier.sv
// Bench for cmn_seq_multiplier: one instance without and one with early exit.
module tb_cmn_seq_multiplier;

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          acc;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        recv_val [2];
    logic        recv_rdy [2];
    logic [31:0] msg_a    [2];
    logic [31:0] msg_b    [2];
    logic        send_val [2];
    logic        send_rdy [2] = '{1'b0, 1'b0};
    logic [63:0] send_msg [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   hold     [2] = '{0, 0};
    bit   rnd      [2] = '{1'b0, 1'b0};
    int   stall    [2] = '{0, 0};
    bit   prev_val [2] = '{1'b0, 1'b0};
    bit   post_xfer[2] = '{1'b0, 1'b0};
    rec_t sb0[$];
    rec_t sb1[$];
    vec_t vt[11];

    cmn_seq_multiplier #(.p_nbits(32), .p_early_exit(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]),
        .recv_msg_a(msg_a[0]), .recv_msg_b(msg_b[0]),
        .send_val(send_val[0]), .send_rdy(send_rdy[0]), .send_msg(send_msg[0])
    );

    cmn_seq_multiplier #(.p_nbits(32), .p_early_exit(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]),
        .recv_msg_a(msg_a[1]), .recv_msg_b(msg_b[1]),
        .send_val(send_val[1]), .send_rdy(send_rdy[1]), .send_msg(send_msg[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic rec_t sb_front(input int i);
        return (i == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int i, input rec_t r);
        if (i == 0) sb0.push_back(r); else sb1.push_back(r);
    endtask

    task automatic sb_pop(input int i);
        if (i == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    endtask

    // Independent latency reference: N steps, or MSB position + 1 with early exit
    function automatic int model_lat(input int ee, input logic [31:0] b);
        if (ee == 0) return 32;
        for (int k = 31; k >= 0; k--) if (b[k]) return k + 1;
        return 1;
    endfunction

    // Offer one pair; the expected record is queued at the negedge before the accept edge
    task automatic drive_pair(input int i, input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] ep, input int el);
        rec_t r;
        int   t;
        bit   done;
        t    = 0;
        done = 1'b0;
        @(negedge clk);
        recv_val[i] = 1'b1;
        msg_a[i]    = a;
        msg_b[i]    = b;
        while (!done) begin
            if (recv_rdy[i]) begin
                r.prod = ep;
                r.lat  = el;
                r.acc  = cyc + 1;
                sb_push(i, r);
                done = 1'b1;
            end
            @(negedge clk);
            if (!done) begin
                t++;
                if (t > 3000) begin
                    chk("accept_timeout", 64'(recv_rdy[i]), 64'd1);
                    done = 1'b1;
                end
            end
        end
        recv_val[i] = 1'b0;
        msg_a[i]    = $urandom;
        msg_b[i]    = $urandom;
    endtask

    // Wait for all queued products to drain
    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while ((sb_size(i) != 0 || send_val[i]) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            chk("drain_timeout", 64'(sb_size(i)), 64'd0);
            if (i == 0) sb0.delete(); else sb1.delete();
        end
        @(negedge clk);
    endtask

    // Output monitor and send_rdy driver
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                prev_val[i]  = 1'b0;
                post_xfer[i] = 1'b0;
                stall[i]     = 0;
            end else begin
                if (post_xfer[i]) begin
                    chk("send_val_drop", 64'(send_val[i]), 64'd0);
                    post_xfer[i] = 1'b0;
                end
                if (send_val[i]) begin
                    chk("recv_rdy_in_done", 64'(recv_rdy[i]), 64'd0);
                    if (sb_size(i) == 0) begin
                        chk("unexpected_send_val", 64'(send_val[i]), 64'd0);
                        send_rdy[i] = 1'b1;
                    end else begin
                        if (!prev_val[i])
                            chk("latency", 64'(cyc - sb_front(i).acc), 64'(sb_front(i).lat));
                        chk("product", send_msg[i], sb_front(i).prod);
                        if (stall[i] < hold[i]) begin
                            send_rdy[i] = 1'b0;
                            stall[i]++;
                        end else begin
                            send_rdy[i] = rnd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                        end
                        if (send_rdy[i]) begin
                            sb_pop(i);
                            post_xfer[i] = 1'b1;
                            stall[i]     = 0;
                        end
                    end
                end else begin
                    send_rdy[i] = rnd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                prev_val[i] = send_val[i];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 32'd3,         32'd5,         64'd15,                  32};
        vt[1]  = '{0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001,    32};
        vt[2]  = '{0, 32'h12345678,  32'd0,         64'd0,                   32};
        vt[3]  = '{0, 32'd0,         32'h00012345,  64'd0,                   32};
        vt[4]  = '{0, 32'h00010000,  32'h00010000,  64'h0000000100000000,    32};
        vt[5]  = '{1, 32'd3,         32'd5,         64'd15,                  3};
        vt[6]  = '{1, 32'd1,         32'h80000000,  64'h0000000080000000,    32};
        vt[7]  = '{1, 32'h12345678,  32'd0,         64'd0,                   1};
        vt[8]  = '{1, 32'hDEADBEEF,  32'd2,         64'h00000001BD5B7DDE,    2};
        vt[9]  = '{1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001,    32};
        vt[10] = '{1, 32'd5,         32'd1,         64'd5,                   1};

        for (int i = 0; i < 2; i++) begin
            recv_val[i] = 1'b0;
            msg_a[i]    = '0;
            msg_b[i]    = '0;
        end

        // Reset: low for three cycles, outputs quiet, ready the cycle after release
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("reset_recv_rdy", 64'(recv_rdy[i]), 64'd0);
                chk("reset_send_val", 64'(send_val[i]), 64'd0);
                chk("reset_send_msg", send_msg[i], 64'd0);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_rdy0", 64'(recv_rdy[0]), 64'd1);
        chk("post_reset_rdy1", 64'(recv_rdy[1]), 64'd1);

        // Directed vector table
        for (int v = 0; v < 11; v++) begin
            drive_pair(vt[v].inst, vt[v].a, vt[v].b, vt[v].prod, vt[v].lat);
            wait_idle(vt[v].inst);
        end

        // Backpressure: product held for five stalled cycles, single transfer
        hold[0] = 5;
        drive_pair(0, 32'd7, 32'd9, 64'd63, 32);
        wait_idle(0);
        hold[0] = 0;

        // Back-to-back: second pair held on recv_val while busy
        drive_pair(0, 32'd3, 32'd5, 64'd15, 32);
        recv_val[0] = 1'b1;
        msg_a[0]    = 32'd2;
        msg_b[0]    = 32'd2;
        repeat (5) begin
            @(negedge clk);
            chk("busy_recv_rdy", 64'(recv_rdy[0]), 64'd0);
        end
        drive_pair(0, 32'd2, 32'd2, 64'd4, 32);
        wait_idle(0);

        // Mid-operation reset abandons the product
        drive_pair(0, 32'd3, 32'd5, 64'd15, 32);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        sb0.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midreset_send_val", 64'(send_val[0]), 64'd0);
            chk("midreset_recv_rdy", 64'(recv_rdy[0]), 64'd0);
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("no_send_after_reset", 64'(send_val[0]), 64'd0);
        end
        drive_pair(0, 32'd6, 32'd7, 64'd42, 32);
        wait_idle(0);

        // Random pairs with random send_rdy against a golden product
        for (int i = 0; i < 2; i++) begin
            rnd[i] = 1'b1;
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                logic [31:0] b;
                a = $urandom;
                b = $urandom;
                if (i == 1) b = b >> $urandom_range(0, 31);
                case ($urandom_range(0, 15))
                    0: a = '0;
                    1: b = '0;
                    2: begin a = '1; b = '1; end
                    default: ;
                endcase
                drive_pair(i, a, b, 64'(a) * 64'(b), model_lat(i, b));
            end
            wait_idle(i);
            rnd[i] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
